timer_scheduler: RTL and testbench

Time-multiplexes one 8-bit countdown resource among NUM_REQ requesters. Each requester presents a duration and a level request. The block grants requesters round-robin, counts the granted duration down, and returns a one-cycle done pulse to the owner. It sits between the control FSMs that need delays and the shared countdown datapath, so each FSM no longer needs its own timer.

---
 rtl/timer_scheduler.sv | 132 +++++++++++++
 tb/tb_timer_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one DUR_W-bit countdown among NUM_REQ requesters.
// Grants with a one-cycle ack, counts the captured duration down, and returns a one-cycle done.
module timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DUR_W   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DUR_W-1:0] duration,
  input  logic                     cancel,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [ID_W-1:0]          active_id,
  output logic [DUR_W-1:0]         remaining
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic               r_busy, w_busy_nxt;
  logic [ID_W-1:0]    r_active_id, w_id_nxt;
  logic [DUR_W-1:0]   r_remaining, w_rem_nxt;
  logic [ID_W-1:0]    r_rr_last, w_rr_nxt;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_cand;
  logic [DUR_W-1:0]   w_win_dur;

  // A zero duration is promoted to one so it times exactly like a one-cycle wait.
  function automatic logic [DUR_W-1:0] load_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] last, input int k);
    int s;
    s = int'(last) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = rr_index(r_rr_last, k);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
    w_win_dur = duration[int'(w_winner)*DUR_W +: DUR_W];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_busy_nxt  = r_busy;
    w_id_nxt    = r_active_id;
    w_rem_nxt   = r_remaining;
    w_rr_nxt    = r_rr_last;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_found) begin
          w_state_nxt         = S_COUNT;
          w_ack_nxt[w_winner] = 1'b1;
          w_id_nxt            = w_winner;
          w_rr_nxt            = w_winner;
          w_busy_nxt          = 1'b1;
          w_rem_nxt           = load_dur(w_win_dur);
        end
      end
      S_COUNT: begin
        if (cancel) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_rem_nxt   = '0;
        end else if (r_remaining <= DUR_W'(1)) begin
          // Saturating at zero keeps the counter from ever wrapping.
          w_state_nxt             = S_DONE;
          w_rem_nxt               = '0;
          w_done_nxt[r_active_id] = 1'b1;
        end else begin
          w_rem_nxt = r_remaining - DUR_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ack       <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_active_id <= '0;
      r_remaining <= '0;
      r_rr_last   <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_active_id <= w_id_nxt;
      r_remaining <= w_rem_nxt;
      r_rr_last   <= w_rr_nxt;
    end
  end

  assign ack       = r_ack;
  assign done      = r_done;
  assign busy      = r_busy;
  assign active_id = r_active_id;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed scenarios plus randomized traffic against a
// timestamp-based model (grant cycle + effective duration determine every output).
module tb_timer_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] duration;
  logic           cancel;
  logic [N-1:0]   ack;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     active_id;
  logic [W-1:0]   remaining;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model state
  bit         m_own;
  int         m_owner, m_ack_cyc, m_len, m_rr;
  logic [N-1:0] e_ack, e_done;
  logic       e_busy;
  int         e_id, e_rem;

  timer_scheduler #(.NUM_REQ(N), .DUR_W(W), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .duration(duration), .cancel(cancel),
    .ack(ack), .done(done), .busy(busy), .active_id(active_id), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; cancel = 1'b0; duration = '0;
    tick();
    rst = 1'b0;
  endtask

  // Predict outputs after the edge just taken; inputs still hold their pre-edge values.
  task automatic model_step();
    int el;
    e_ack  = '0;
    e_done = '0;
    if (rst) begin
      m_own = 0; m_rr = N - 1; e_id = 0; e_rem = 0; e_busy = 1'b0;
      return;
    end
    if (m_own) begin
      el = (cyc - 1) - m_ack_cyc;
      if (el < m_len) begin
        if (cancel) begin
          m_own = 0; e_busy = 1'b0; e_rem = 0;
        end else if (el + 1 == m_len) begin
          e_done[m_owner] = 1'b1; e_rem = 0; e_busy = 1'b1;
        end else begin
          e_rem = m_len - el - 1;
        end
      end else begin
        m_own = 0; e_busy = 1'b0;
      end
    end else begin
      e_busy = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!m_own && req[j]) begin
          m_own = 1; m_owner = j; m_rr = j; m_ack_cyc = cyc;
          m_len = (duration[j*W +: W] == 0) ? 1 : int'(duration[j*W +: W]);
          e_ack[j] = 1'b1; e_id = j; e_rem = m_len; e_busy = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ack !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || active_id !== 2'd0 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL reset ack=%b done=%b busy=%b id=%0d rem=%0d expected all zero",
               ack, done, busy, active_id, remaining);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; duration[2*W +: W] = 8'd5;
    tick();
    checks++;
    if (ack !== 4'b0100 || active_id !== 2'd2 || remaining !== 8'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack ack=%b id=%0d rem=%0d busy=%b expected 0100/2/5/1",
               ack, active_id, remaining, busy);
    end
    req = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (remaining !== 8'(5 - i) || done !== 4'b0 || ack !== 4'b0) begin
        errors++;
        $display("FAIL single_count step=%0d rem=%0d done=%b expected rem=%0d done=0",
                 i, remaining, done, 5 - i);
      end
    end
    tick();
    checks++;
    if (done !== 4'b0100 || remaining !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done done=%b rem=%0d busy=%b expected 0100/0/1", done, remaining, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b done=%b expected 0/0000", busy, done);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] xa, xd;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) duration[i*W +: W] = 8'd3;
    for (int t = 0; t < 25; t++) begin
      tick();
      xa = (t % 5 == 0) ? 4'(1 << ((t / 5) % 4)) : 4'b0;
      xd = (t % 5 == 3) ? 4'(1 << ((t / 5) % 4)) : 4'b0;
      checks++;
      if (ack !== xa || done !== xd || busy !== (t % 5 != 4)) begin
        errors++;
        $display("FAIL rr t=%0d ack=%b done=%b busy=%b expected %b/%b/%b",
                 t, ack, done, busy, xa, xd, (t % 5 != 4));
      end
    end
    req = '0;
  endtask

  task automatic test_zero_dur();
    for (int d = 0; d <= 1; d++) begin
      do_reset();
      req = 4'b0010; duration[1*W +: W] = 8'(d);
      tick();
      checks++;
      if (ack !== 4'b0010 || remaining !== 8'd1) begin
        errors++;
        $display("FAIL dur%0d_ack ack=%b rem=%0d expected 0010/1", d, ack, remaining);
      end
      req = '0;
      tick();
      checks++;
      if (done !== 4'b0010) begin
        errors++;
        $display("FAIL dur%0d_done done=%b expected 0010", d, done);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 4'b0) begin
        errors++;
        $display("FAIL dur%0d_idle busy=%b done=%b expected 0/0000", d, busy, done);
      end
    end
  endtask

  task automatic test_cancel();
    do_reset();
    req = 4'b0001; duration[0 +: W] = 8'd200;
    tick();
    req = 4'b0010; duration[1*W +: W] = 8'd2;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (remaining !== 8'(200 - i)) begin
        errors++;
        $display("FAIL cancel_count step=%0d rem=%0d expected %0d", i, remaining, 200 - i);
      end
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || remaining !== 8'd0 || done !== 4'b0 || ack !== 4'b0) begin
      errors++;
      $display("FAIL cancel_idle busy=%b rem=%0d done=%b ack=%b expected 0/0/0000/0000",
               busy, remaining, done, ack);
    end
    tick();
    checks++;
    if (ack !== 4'b0010 || active_id !== 2'd1 || done !== 4'b0) begin
      errors++;
      $display("FAIL cancel_next ack=%b id=%0d done=%b expected 0010/1/0000", ack, active_id, done);
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000; duration[3*W +: W] = 8'd4;
    tick();
    req = '0;
    tick();
    tick();
    checks++;
    if (remaining !== 8'd2) begin
      errors++;
      $display("FAIL rstmid_pre rem=%0d expected 2", remaining);
    end
    rst = 1'b1; req = 4'b1111;
    tick();
    rst = 1'b0;
    checks++;
    if (ack !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || active_id !== 2'd0 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_state ack=%b done=%b busy=%b id=%0d rem=%0d expected all zero",
               ack, done, busy, active_id, remaining);
    end
    tick();
    checks++;
    if (ack !== 4'b0001 || done !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_prio ack=%b done=%b expected 0001/0000", ack, done);
    end
    req = '0;
  endtask

  task automatic test_cancel_last();
    do_reset();
    req = 4'b0100; duration[2*W +: W] = 8'd2;
    tick();
    req = '0;
    tick();
    checks++;
    if (remaining !== 8'd1) begin
      errors++;
      $display("FAIL cancel1_pre rem=%0d expected 1", remaining);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (done !== 4'b0 || busy !== 1'b0 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL cancel1_post done=%b busy=%b rem=%0d expected 0000/0/0", done, busy, remaining);
    end
    tick();
    checks++;
    if (done !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel1_late done=%b busy=%b expected 0000/0", done, busy);
    end
  endtask

  task automatic test_max();
    do_reset();
    req = 4'b0001; duration[0 +: W] = 8'd255;
    tick();
    req = '0;
    checks++;
    if (ack !== 4'b0001 || remaining !== 8'd255) begin
      errors++;
      $display("FAIL max_ack ack=%b rem=%0d expected 0001/255", ack, remaining);
    end
    for (int i = 1; i <= 254; i++) begin
      tick();
      checks++;
      if (remaining !== 8'(255 - i) || done !== 4'b0) begin
        errors++;
        $display("FAIL max_count step=%0d rem=%0d done=%b expected %0d/0000", i, remaining, done, 255 - i);
      end
    end
    tick();
    checks++;
    if (done !== 4'b0001 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL max_done done=%b rem=%0d expected 0001/0", done, remaining);
    end
  endtask

  task automatic test_random();
    do_reset();
    m_own = 0; m_rr = N - 1; e_id = 0; e_rem = 0; e_busy = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) duration[i*W +: W] = 8'($urandom_range(0, 12));
      cancel = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 399) == 0);
      tick();
      model_step();
      checks++;
      if (ack !== e_ack) begin
        errors++;
        $display("FAIL rand_ack t=%0d got=%b exp=%b", t, ack, e_ack);
      end
      checks++;
      if (done !== e_done) begin
        errors++;
        $display("FAIL rand_done t=%0d got=%b exp=%b", t, done, e_done);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL rand_busy t=%0d got=%b exp=%b", t, busy, e_busy);
      end
      checks++;
      if (active_id !== 2'(e_id)) begin
        errors++;
        $display("FAIL rand_id t=%0d got=%0d exp=%0d", t, active_id, e_id);
      end
      checks++;
      if (remaining !== 8'(e_rem)) begin
        errors++;
        $display("FAIL rand_rem t=%0d got=%0d exp=%0d", t, remaining, e_rem);
      end
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (e_ack[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
        end
      end
    end
    cancel = 1'b0;
    req = '0;
  endtask

  initial begin
    rst = 1'b0; req = '0; cancel = 1'b0; duration = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_dur();
    test_cancel();
    test_reset_mid();
    test_cancel_last();
    test_max();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
